// File: rtl/sdram_req_gen.sv
// Ring-buffer burst requester for the SDRAM request/ack port; 1-cycle decision, request held until ack (no withdrawal).
// Optional SDRAM_REQ_ACKCHK_EN adds a per-transfer ack counter and sticky ack_err output.
module sdram_req_gen #(
    parameter int BURST_LEN     = 256,
    parameter int ADDR_W        = 24,
    parameter int BASE_ADDR     = 0,
    parameter int REGION_BURSTS = 16,
    parameter int RD_FIFO_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic              rd_enable,
    input  logic [9:0]        wrf_used,
    input  logic [9:0]        rdf_used,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [9:0]        sdwr_byte,
    output logic [9:0]        sdrd_byte,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W-1:0] sys_wraddr,
    output logic [ADDR_W-1:0] sys_rdaddr,
    output logic [15:0]       credit,
    output logic              busy
`ifdef SDRAM_REQ_ACKCHK_EN
    ,
    output logic              ack_err
`endif
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER} state_t;

    localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   REGION_END = (ADDR_W+1)'(BASE_ADDR + REGION_BURSTS * BURST_LEN);

    state_t            state, state_n;
    logic              wr_req_n, rd_req_n;
    logic [ADDR_W-1:0] wraddr_n, rdaddr_n;
    logic [15:0]       credit_n;
    logic              last_wr, last_wr_n;
    logic              ack_seen, ack_seen_n;
    logic              wr_ok, rd_ok, wr_done, rd_done;

    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + (ADDR_W+1)'(BURST_LEN);
        if (s >= REGION_END)
            return BASE_A;
        return s[ADDR_W-1:0];
    endfunction

    assign sdwr_byte = 10'(BURST_LEN);
    assign sdrd_byte = 10'(BURST_LEN);
    assign busy      = (state != IDLE);

    // Free space in the read FIFO is computed in 11 bits so a full 512-word FIFO compares correctly.
    assign wr_ok = sdram_init_done && ({1'b0, wrf_used} >= 11'(BURST_LEN))
                   && (credit < 16'(REGION_BURSTS));
    assign rd_ok = sdram_init_done && rd_enable && (credit != 16'd0)
                   && ((11'(RD_FIFO_DEPTH) - {1'b0, rdf_used}) >= 11'(BURST_LEN));

    assign wr_done = (state == WR_XFER) && ack_seen && !sdram_wr_ack;
    assign rd_done = (state == RD_XFER) && ack_seen && !sdram_rd_ack;

    always_comb begin
        state_n    = state;
        wr_req_n   = sdram_wr_req;
        rd_req_n   = sdram_rd_req;
        wraddr_n   = sys_wraddr;
        rdaddr_n   = sys_rdaddr;
        credit_n   = credit;
        last_wr_n  = last_wr;
        ack_seen_n = ack_seen;
        case (state)
            IDLE: begin
                if (wr_ok && rd_ok)
                    state_n = last_wr ? RD_REQ : WR_REQ;
                else if (wr_ok)
                    state_n = WR_REQ;
                else if (rd_ok)
                    state_n = RD_REQ;
            end
            WR_REQ: begin
                // An ack only counts once our request is actually visible on the port.
                if (sdram_wr_req && sdram_wr_ack) begin
                    wr_req_n   = 1'b0;
                    ack_seen_n = 1'b1;
                    state_n    = WR_XFER;
                end else begin
                    wr_req_n = 1'b1;
                end
            end
            WR_XFER: begin
                if (wr_done) begin
                    wraddr_n   = advance(sys_wraddr);
                    credit_n   = credit + 16'd1;
                    last_wr_n  = 1'b1;
                    ack_seen_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            RD_REQ: begin
                if (sdram_rd_req && sdram_rd_ack) begin
                    rd_req_n   = 1'b0;
                    ack_seen_n = 1'b1;
                    state_n    = RD_XFER;
                end else begin
                    rd_req_n = 1'b1;
                end
            end
            RD_XFER: begin
                if (rd_done) begin
                    rdaddr_n   = advance(sys_rdaddr);
                    credit_n   = credit - 16'd1;
                    last_wr_n  = 1'b0;
                    ack_seen_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: begin
                state_n  = IDLE;
                wr_req_n = 1'b0;
                rd_req_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            sys_wraddr   <= BASE_A;
            sys_rdaddr   <= BASE_A;
            credit       <= 16'd0;
            last_wr      <= 1'b0;
            ack_seen     <= 1'b0;
        end else begin
            state        <= state_n;
            sdram_wr_req <= wr_req_n;
            sdram_rd_req <= rd_req_n;
            sys_wraddr   <= wraddr_n;
            sys_rdaddr   <= rdaddr_n;
            credit       <= credit_n;
            last_wr      <= last_wr_n;
            ack_seen     <= ack_seen_n;
        end
    end

`ifdef SDRAM_REQ_ACKCHK_EN
    logic [9:0] ack_cnt, ack_cnt_n;
    logic       ack_err_n, ack_hit;

    assign ack_hit = ((state == WR_REQ) && sdram_wr_req && sdram_wr_ack)
                  || ((state == WR_XFER) && sdram_wr_ack)
                  || ((state == RD_REQ) && sdram_rd_req && sdram_rd_ack)
                  || ((state == RD_XFER) && sdram_rd_ack);

    always_comb begin
        ack_cnt_n = ack_cnt;
        ack_err_n = ack_err;
        if (ack_hit)
            ack_cnt_n = ack_cnt + 10'd1;
        if (wr_done || rd_done) begin
            if (ack_cnt != 10'(BURST_LEN))
                ack_err_n = 1'b1;
            ack_cnt_n = 10'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt <= 10'd0;
            ack_err <= 1'b0;
        end else begin
            ack_cnt <= ack_cnt_n;
            ack_err <= ack_err_n;
        end
    end
`endif

endmodule
